// File: rtl/mem_access_ctrl.sv
// SRAM/MMIO access sequencer between the SLC-3 ISDU strobes and an asynchronous SRAM.
// Define MMIO_EN to decode IO_ADDR as the switch/hex-display I/O word.
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic [15:0] Switches,
    output logic [15:0] Data_to_CPU,
    output logic        Mem_Ready,
    output logic [15:0] Hex_Out,
    output logic [19:0] SRAM_ADDR,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    inout  wire  [15:0] SRAM_DQ
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

`ifdef MMIO_EN
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        READ_WAIT  = 3'd1,
        READ_DONE  = 3'd2,
        WRITE_WAIT = 3'd3,
        WRITE_HOLD = 3'd4,
        WRITE_DONE = 3'd5,
        IO_READ    = 3'd6,
        IO_WRITE   = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        READ_WAIT  = 3'd1,
        READ_DONE  = 3'd2,
        WRITE_WAIT = 3'd3,
        WRITE_HOLD = 3'd4,
        WRITE_DONE = 3'd5
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        dq_oe_q, dq_oe_d;
    logic        ready_q, ready_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;

`ifdef MMIO_EN
    logic [15:0] hex_q, hex_d;
    logic        is_io;

    assign is_io = (MAR == IO_ADDR);
`else
    // Without the I/O decode the switches and I/O address have no consumer.
    logic unused_io;

    assign unused_io = ^{Switches, IO_ADDR};
`endif

    // State and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            ready_q <= 1'b0;
            addr_q  <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            dq_oe_q <= dq_oe_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge Clk) begin
        wdata_q <= wdata_d;
    end

`ifdef MMIO_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hex_q <= 16'h0000;
        end else begin
            hex_q <= hex_d;
        end
    end
`endif

    // Next-state logic; strobes are levels, write wins when both are high.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (Mem_WE) begin
`ifdef MMIO_EN
                    if (is_io) begin
                        state_d = IO_WRITE;
                    end else begin
                        state_d = WRITE_WAIT;
                        cnt_d   = WAIT_LD;
                    end
`else
                    state_d = WRITE_WAIT;
                    cnt_d   = WAIT_LD;
`endif
                end else if (Mem_OE) begin
`ifdef MMIO_EN
                    if (is_io) begin
                        state_d = IO_READ;
                    end else begin
                        state_d = READ_WAIT;
                        cnt_d   = WAIT_LD;
                    end
`else
                    state_d = READ_WAIT;
                    cnt_d   = WAIT_LD;
`endif
                end
            end
            READ_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = READ_DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            READ_DONE: begin
                if (!Mem_OE) begin
                    state_d = IDLE;
                end
            end
            WRITE_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = WRITE_HOLD;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRITE_HOLD: begin
                state_d = WRITE_DONE;
            end
            WRITE_DONE: begin
                if (!Mem_WE) begin
                    state_d = IDLE;
                end
            end
`ifdef MMIO_EN
            IO_READ: begin
                state_d = READ_DONE;
            end
            IO_WRITE: begin
                state_d = WRITE_DONE;
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output logic: SRAM controls follow the state being entered so they are registered.
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        ready_d = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MMIO_EN
        hex_d   = hex_q;
`endif
        case (state_d)
            READ_WAIT: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            WRITE_WAIT: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            WRITE_HOLD: begin
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            READ_DONE, WRITE_DONE: begin
                ready_d = (state_q != state_d);
            end
            default: begin
                ce_n_d = 1'b1;
            end
        endcase

        if (state_q == IDLE && (state_d == READ_WAIT || state_d == WRITE_WAIT)) begin
            addr_d = MAR;
        end
        if (state_q == IDLE && state_d == WRITE_WAIT) begin
            wdata_d = MDR;
        end
        if (state_q == READ_WAIT && state_d == READ_DONE) begin
            rdata_d = SRAM_DQ;
        end
`ifdef MMIO_EN
        if (state_q == IDLE && state_d == IO_READ) begin
            rdata_d = Switches;
        end
        if (state_q == IDLE && state_d == IO_WRITE) begin
            hex_d = MDR;
        end
`endif
    end

    assign SRAM_DQ     = dq_oe_q ? wdata_q : 16'hzzzz;
    assign SRAM_ADDR   = {4'b0000, addr_q};
    assign SRAM_CE_N   = ce_n_q;
    assign SRAM_OE_N   = oe_n_q;
    assign SRAM_WE_N   = we_n_q;
    assign SRAM_UB_N   = 1'b0;
    assign SRAM_LB_N   = 1'b0;
    assign Data_to_CPU = rdata_q;
    assign Mem_Ready   = ready_q;
`ifdef MMIO_EN
    assign Hex_Out     = hex_q;
`else
    assign Hex_Out     = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance with WAIT_CYCLES=1, one with 3,
// each on its own SRAM bus backed by a shared behavioural memory.
module tb_mem_access_ctrl;

    localparam logic [15:0] MARK = 16'hD00D;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset, oe1, we1, oe3, we3;
    logic [15:0] MAR, MDR, Switches;
    logic [15:0] d1, d3, hex1, hex3;
    logic        rdy1, rdy3;
    logic [19:0] a1, a3;
    logic        ce1, oen1, wen1, ub1, lb1;
    logic        ce3, oen3, wen3, ub3, lb3;
    wire  [15:0] dq1, dq3;
    logic        en1, en3;
    logic [15:0] drv1, drv3;
    logic [15:0] mem [0:255];

    int n_cmp = 0;
    int n_err = 0;

    mem_access_ctrl #(.WAIT_CYCLES(1), .IO_ADDR(16'hFFFF)) u1 (
        .Clk(Clk), .Reset(Reset), .Mem_OE(oe1), .Mem_WE(we1),
        .MAR(MAR), .MDR(MDR), .Switches(Switches),
        .Data_to_CPU(d1), .Mem_Ready(rdy1), .Hex_Out(hex1), .SRAM_ADDR(a1),
        .SRAM_CE_N(ce1), .SRAM_OE_N(oen1), .SRAM_WE_N(wen1),
        .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_DQ(dq1)
    );

    mem_access_ctrl #(.WAIT_CYCLES(3), .IO_ADDR(16'hFFFF)) u3 (
        .Clk(Clk), .Reset(Reset), .Mem_OE(oe3), .Mem_WE(we3),
        .MAR(MAR), .MDR(MDR), .Switches(Switches),
        .Data_to_CPU(d3), .Mem_Ready(rdy3), .Hex_Out(hex3), .SRAM_ADDR(a3),
        .SRAM_CE_N(ce3), .SRAM_OE_N(oen3), .SRAM_WE_N(wen3),
        .SRAM_UB_N(ub3), .SRAM_LB_N(lb3), .SRAM_DQ(dq3)
    );

    // SRAM model: drives read data when selected for read, a marker when deselected.
    assign en1  = ce1 || !oen1;
    assign drv1 = ce1 ? MARK : mem[a1[7:0]];
    assign dq1  = en1 ? drv1 : 16'hzzzz;
    assign en3  = ce3 || !oen3;
    assign drv3 = ce3 ? MARK : mem[a3[7:0]];
    assign dq3  = en3 ? drv3 : 16'hzzzz;

    always @(posedge Clk) begin
        if (!ce1 && !wen1) mem[a1[7:0]] <= dq1;
        if (!ce3 && !wen3) mem[a3[7:0]] <= dq3;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'hBEEF;
        Reset = 1'b1; oe1 = 1'b0; we1 = 1'b0; oe3 = 1'b0; we3 = 1'b0;
        MAR = 16'h0000; MDR = 16'h0000; Switches = 16'h0000;
        tick(); tick();

        chk("rst_ce_n", ce1, 1); chk("rst_oe_n", oen1, 1); chk("rst_we_n", wen1, 1);
        chk("rst_ub_lb", {ub1, lb1}, 0); chk("rst_data", d1, 0); chk("rst_ready", rdy1, 0);
        chk("rst_hex", hex3, 0); chk("rst_addr", a3, 0); chk("rst_dq_released", dq3, MARK);
        Reset = 1'b0;
        tick();

        // Read 0x0010, one wait cycle
        MAR = 16'h0010; oe1 = 1'b1;
        tick();
        chk("rd1_oe_low", oen1, 0); chk("rd1_ce_low", ce1, 0);
        chk("rd1_addr", a1, 20'h00010); chk("rd1_ready_early", rdy1, 0);
        tick();
        chk("rd1_oe_high", oen1, 1); chk("rd1_ce_high", ce1, 1);
        chk("rd1_data", d1, 16'hBEEF); chk("rd1_ready", rdy1, 1);
        tick();
        chk("rd1_no_second_pulse", rdy1, 0); chk("rd1_no_second_oe", oen1, 1);
        oe1 = 1'b0;
        tick();
        chk("rd1_idle_ready", rdy1, 0); chk("rd1_data_hold", d1, 16'hBEEF);
        tick();

        // Write 0x0020 = 0x1234, three wait cycles
        MAR = 16'h0020; MDR = 16'h1234; we3 = 1'b1;
        tick();
        chk("wr3_we_n1", wen3, 0); chk("wr3_ce_n1", ce3, 0);
        chk("wr3_oe_n1", oen3, 1); chk("wr3_dq_n1", dq3, 16'h1234);
        tick();
        chk("wr3_we_n2", wen3, 0);
        tick();
        chk("wr3_we_n3", wen3, 0); chk("wr3_ready_n3", rdy3, 0);
        tick();
        chk("wr3_hold_we", wen3, 1); chk("wr3_hold_ce", ce3, 0);
        chk("wr3_hold_dq", dq3, 16'h1234); chk("wr3_hold_ready", rdy3, 0);
        tick();
        chk("wr3_ready", rdy3, 1); chk("wr3_done_ce", ce3, 1); chk("wr3_done_dq", dq3, MARK);
        we3 = 1'b0; MDR = 16'h0000;
        tick();
        chk("wr3_ready_clear", rdy3, 0);
        tick();

        // Readback 0x0020
        MAR = 16'h0020; oe3 = 1'b1;
        tick();
        chk("rb3_oe_n1", oen3, 0);
        tick(); tick();
        chk("rb3_oe_n3", oen3, 0); chk("rb3_ready_early", rdy3, 0);
        tick();
        chk("rb3_data", d3, 16'h1234); chk("rb3_ready", rdy3, 1); chk("rb3_oe_high", oen3, 1);
        oe3 = 1'b0;
        tick(); tick();

        // Both strobes high: the write wins
        MAR = 16'h0030; MDR = 16'h5A5A; oe1 = 1'b1; we1 = 1'b1;
        tick();
        chk("both_we_low", wen1, 0); chk("both_oe_n1", oen1, 1);
        tick();
        chk("both_hold_we", wen1, 1); chk("both_oe_n2", oen1, 1); chk("both_hold_ce", ce1, 0);
        tick();
        chk("both_ready", rdy1, 1); chk("both_oe_n3", oen1, 1);
        oe1 = 1'b0; we1 = 1'b0;
        tick();
        chk("both_oe_n4", oen1, 1); chk("both_ready_clear", rdy1, 0);
        chk("both_mem", mem[8'h30], 16'h5A5A);
        tick();

`ifdef MMIO_EN
        // I/O read of the switches and write of the hex display
        MAR = 16'hFFFF; Switches = 16'h00A5; oe3 = 1'b1;
        tick();
        chk("ior_data", d3, 16'h00A5); chk("ior_ce_n1", ce3, 1);
        chk("ior_oe_n1", oen3, 1); chk("ior_ready_early", rdy3, 0);
        tick();
        chk("ior_ready", rdy3, 1); chk("ior_ce_n2", ce3, 1); chk("ior_addr_kept", a3, 20'h00020);
        oe3 = 1'b0;
        tick(); tick();
        MDR = 16'h0042; we3 = 1'b1;
        tick();
        chk("iow_hex", hex3, 16'h0042); chk("iow_ce_n1", ce3, 1); chk("iow_we_n1", wen3, 1);
        tick();
        chk("iow_ready", rdy3, 1); chk("iow_ce_n2", ce3, 1);
        we3 = 1'b0;
        tick(); tick();
`else
        // IO_ADDR is plain SRAM in this build
        MAR = 16'hFFFF; MDR = 16'hCAFE; Switches = 16'h00A5; we1 = 1'b1;
        tick();
        chk("ffw_we_low", wen1, 0); chk("ffw_addr", a1, 20'h0FFFF);
        tick(); tick();
        chk("ffw_ready", rdy1, 1);
        we1 = 1'b0;
        tick(); tick();
        oe1 = 1'b1;
        tick();
        chk("ffr_oe_low", oen1, 0);
        tick();
        chk("ffr_data", d1, 16'hCAFE); chk("ffr_ready", rdy1, 1); chk("ffr_hex_zero", hex1, 0);
        oe1 = 1'b0;
        tick(); tick();
`endif

        // Reset in the middle of WRITE_WAIT, strobe still held afterwards
        MAR = 16'h0040; MDR = 16'h7777; we3 = 1'b1;
        tick();
        chk("rstw_we_low", wen3, 0);
        tick();
        Reset = 1'b1;
        tick();
        chk("rstw_we_n", wen3, 1); chk("rstw_ce_n", ce3, 1); chk("rstw_dq", dq3, MARK);
        chk("rstw_hex", hex3, 0); chk("rstw_ready", rdy3, 0);
        chk("rstw_addr", a3, 0); chk("rstw_data", d3, 0);
        Reset = 1'b0;
        tick();
        chk("rstw_restart_we", wen3, 0); chk("rstw_restart_addr", a3, 20'h00040);
        we3 = 1'b0;
        tick(); tick();
        chk("drop_still_writing", wen3, 0);
        tick();
        chk("drop_hold_we", wen3, 1); chk("drop_hold_ce", ce3, 0);
        tick();
        chk("drop_ready", rdy3, 1);
        tick();
        chk("drop_ready_clear", rdy3, 0); chk("drop_idle_ce", ce3, 1);
        chk("drop_mem", mem[8'h40], 16'h7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
